// File: rtl/operand_regfile.sv
// Eight-entry operand register file with R0 hardwired to zero and two registered read ports.
// Define OPERAND_REGFILE_BYPASS_EN to forward same-edge write data to the read ports.
module operand_regfile #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned NUM_REGS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              op_valid,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [7:0]        wr_count
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic              op_valid_q;
    logic [7:0]        wr_count_q;
    logic              wr_fire;

    assign wr_fire = we && (wr_addr != '0);

    always_comb begin
        op_a_d = (rs1_addr == '0) ? '0 : regs_q[rs1_addr];
        op_b_d = (rs2_addr == '0) ? '0 : regs_q[rs2_addr];
`ifdef OPERAND_REGFILE_BYPASS_EN
        // wr_fire already excludes R0, so R0 reads are never forwarded
        if (wr_fire && (wr_addr == rs1_addr)) op_a_d = wr_data;
        if (wr_fire && (wr_addr == rs2_addr)) op_b_d = wr_data;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_valid_q <= 1'b0;
            wr_count_q <= '0;
        end else begin
            op_valid_q <= rd_en;
            if (rd_en) begin
                op_a_q <= op_a_d;
                op_b_q <= op_b_d;
            end
            if (wr_fire) begin
                regs_q[wr_addr] <= wr_data;
                wr_count_q      <= wr_count_q + 8'd1;
            end
        end
    end

    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign op_valid = op_valid_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_operand_regfile.sv
// Self-checking bench for operand_regfile: directed cases plus random traffic against a
// behavioural model. Honours OPERAND_REGFILE_BYPASS_EN the same way as the design.
module tb_operand_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_en = 1'b0;
    logic [2:0]  rs1_addr = '0, rs2_addr = '0;
    logic [15:0] op_a, op_b;
    logic        op_valid;
    logic        we = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [7:0]  wr_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    operand_regfile dut (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_valid (op_valid),
        .we       (we),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

`ifdef OPERAND_REGFILE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    // Behavioural model: a plain array of register values plus a write counter
    int unsigned m_mem [8];
    int unsigned m_a = 0, m_b = 0, m_cnt = 0;
    bit          m_valid = 1'b0;

    function automatic int unsigned model_read(input int unsigned addr);
        if (addr == 0) return 0;
        if (Bypass && we && wr_addr != 0 && wr_addr == addr) return wr_data;
        return m_mem[addr];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            foreach (m_mem[i]) m_mem[i] = 0;
            m_a = 0; m_b = 0; m_cnt = 0; m_valid = 1'b0;
        end else begin
            m_valid = rd_en;
            if (rd_en) begin
                m_a = model_read(rs1_addr);
                m_b = model_read(rs2_addr);
            end
            if (we && wr_addr != 0) begin
                m_mem[wr_addr] = wr_data;
                m_cnt = (m_cnt + 1) % 256;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started && !rst) begin
            check("cyc_op_a", 32'(op_a), m_a);
            check("cyc_op_b", 32'(op_b), m_b);
            check("cyc_valid", 32'(op_valid), 32'(m_valid));
            check("cyc_count", 32'(wr_count), m_cnt);
        end
    end

    task automatic step(input logic w, input logic [2:0] wa, input logic [15:0] wd,
                        input logic r, input logic [2:0] a1, input logic [2:0] a2);
        @(negedge clk);
        we = w; wr_addr = wa; wr_data = wd;
        rd_en = r; rs1_addr = a1; rs2_addr = a2;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        do_reset();
        started = 1'b1;

        // Reset state and first read
        step(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 3'd5);
        check("rst_read_a", 32'(op_a), 32'h0);
        check("rst_read_b", 32'(op_b), 32'h0);
        check("rst_read_valid", 32'(op_valid), 32'h1);
        check("rst_count", 32'(wr_count), 32'h0);

        // R1=10, R2=15
        step(1'b1, 3'd1, 16'd10, 1'b0, 3'd0, 3'd0);
        step(1'b1, 3'd2, 16'd15, 1'b0, 3'd0, 3'd0);
        check("valid_drop", 32'(op_valid), 32'h0);
        step(1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 3'd2);
        check("r1r2_a", 32'(op_a), 32'd10);
        check("r1r2_b", 32'(op_b), 32'd15);
        check("and_10_15", 32'(op_a & op_b), 32'd10);
        check("or_10_15", 32'(op_a | op_b), 32'd15);
        check("xor_10_15", 32'(op_a ^ op_b), 32'd5);
        idle();
        check("hold_a", 32'(op_a), 32'd10);

        // R3=25, R4=-30
        step(1'b1, 3'd3, 16'd25, 1'b0, 3'd0, 3'd0);
        step(1'b1, 3'd4, 16'hFFE2, 1'b0, 3'd0, 3'd0);
        step(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 3'd4);
        check("neg_a", 32'(op_a), 32'h0019);
        check("neg_b", 32'(op_b), 32'hFFE2);
        check("model_pin_b", m_b, 32'hFFE2);
        check("and_neg", 32'(op_a & op_b), 32'h0000);
        check("or_neg", 32'(op_a | op_b), 32'hFFFB);
        check("xor_neg", 32'(op_a ^ op_b), 32'hFFFB);
        check("count4", 32'(wr_count), 32'd4);

        // R0 writes ignored
        step(1'b1, 3'd0, 16'h1234, 1'b0, 3'd0, 3'd0);
        step(1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 3'd0);
        check("r0_read", 32'(op_a), 32'h0);
        check("r0_count", 32'(wr_count), 32'd4);

        // Same-edge read/write of R6
        step(1'b1, 3'd6, 16'd7, 1'b0, 3'd0, 3'd0);
        step(1'b1, 3'd6, 16'd25, 1'b1, 3'd6, 3'd6);
        check("same_edge_a", 32'(op_a), Bypass ? 32'd25 : 32'd7);
        check("same_edge_b", 32'(op_b), Bypass ? 32'd25 : 32'd7);
        step(1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 3'd6);
        check("next_edge_a", 32'(op_a), 32'd25);

        // Async reset mid-stream
        step(1'b1, 3'd1, 16'd10, 1'b0, 3'd0, 3'd0);
        step(1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 3'd1);
        check("pre_rst_a", 32'(op_a), 32'd10);
        #2 rst = 1'b1;
        #1;
        check("async_valid", 32'(op_valid), 32'h0);
        check("async_a", 32'(op_a), 32'h0);
        check("async_b", 32'(op_b), 32'h0);
        check("async_count", 32'(wr_count), 32'h0);
        #1 rst = 1'b0;
        step(1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 3'd1);
        check("post_rst_r1", 32'(op_a), 32'h0);
        check("post_rst_valid", 32'(op_valid), 32'h1);

        // Counter wrap
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 3'(1 + (i % 7)), 16'(i * 37), 1'b1, 3'(i % 8), 3'((i + 3) % 8));
            if (i == 254) check("count_255", 32'(wr_count), 32'd255);
        end
        check("count_wrap", 32'(wr_count), 32'd0);

        // Random traffic checked by the per-cycle compare
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
